// File: rtl/decode_stage_p.sv
// decode_stage_p: decodes the instruction in D, reads the register file with a writeback bypass,
// detects load-use hazards and registers the decoded fields into the E stage.
module decode_stage_p #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              ValidD,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              FlushE,
  output logic              StallD,
  output logic              ValidE,
  output logic              RegWriteE,
  output logic              ALUSrcE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              JumpE,
  output logic              IllegalE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1_E,
  output logic [XLEN-1:0]   RD2_E,
  output logic [XLEN-1:0]   Imm_Ext_E,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [REG_AW-1:0] RD_E,
  output logic [REG_AW-1:0] RS1_E,
  output logic [REG_AW-1:0] RS2_E
);
  localparam int NREGS = 1 << REG_AW;
  localparam int EW    = 12 + 5 * XLEN + 3 * REG_AW;
  logic [XLEN-1:0]   r_rf [NREGS];
  logic [EW-1:0]     r_e;
  logic [EW-1:0]     w_next;
  logic [6:0]        w_op;
  logic [2:0]        w_f3;
  logic [REG_AW-1:0] w_rd, w_rs1, w_rs2;
  logic [XLEN-1:0]   w_rd1, w_rd2, w_imm;
  logic [XLEN-1:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_j;
  logic [2:0]        w_alu, w_ac;
  logic [1:0]        w_rs;
  logic              w_rw, w_as, w_mw, w_br, w_jp, w_il, w_use1, w_use2, w_bubble;
  assign w_op    = InstrD[6:0];
  assign w_f3    = InstrD[14:12];
  assign w_rd    = REG_AW'(InstrD[11:7]);
  assign w_rs1   = REG_AW'(InstrD[19:15]);
  assign w_rs2   = REG_AW'(InstrD[24:20]);
  assign w_imm_i = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
  assign w_imm_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign w_imm_b = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  assign w_imm_j = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
  // funct7[5] selects sub only for register-register add
  assign w_alu = (w_f3 == 3'b000) ? {2'b00, (w_op == 7'b0110011) & InstrD[30]} :
                 (w_f3 == 3'b010) ? 3'b101 :
                 (w_f3 == 3'b110) ? 3'b011 :
                 (w_f3 == 3'b111) ? 3'b010 : 3'b000;
  always_comb begin
    w_rw   = 1'b0;
    w_as   = 1'b0;
    w_mw   = 1'b0;
    w_br   = 1'b0;
    w_jp   = 1'b0;
    w_il   = 1'b0;
    w_rs   = 2'b00;
    w_ac   = 3'b000;
    w_imm  = '0;
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    case (w_op)
      7'b0110011: begin w_rw = 1'b1; w_ac = w_alu; w_use1 = 1'b1; w_use2 = 1'b1; end
      7'b0010011: begin w_rw = 1'b1; w_as = 1'b1; w_ac = w_alu; w_imm = w_imm_i; w_use1 = 1'b1; end
      7'b0000011: begin w_rw = 1'b1; w_as = 1'b1; w_rs = 2'b01; w_imm = w_imm_i; w_use1 = 1'b1; end
      7'b0100011: begin w_mw = 1'b1; w_as = 1'b1; w_imm = w_imm_s; w_use1 = 1'b1; w_use2 = 1'b1; end
      7'b1100011: begin w_br = 1'b1; w_ac = 3'b001; w_imm = w_imm_b; w_use1 = 1'b1; w_use2 = 1'b1; end
      7'b1101111: begin w_jp = 1'b1; w_rw = 1'b1; w_rs = 2'b10; w_imm = w_imm_j; end
      default:    w_il = 1'b1;
    endcase
  end
  // same-cycle writeback is forwarded so a stalled replay sees the new value
  assign w_rd1 = (w_rs1 == '0) ? '0 : (RegWriteW && RDW == w_rs1) ? ResultW : r_rf[w_rs1];
  assign w_rd2 = (w_rs2 == '0) ? '0 : (RegWriteW && RDW == w_rs2) ? ResultW : r_rf[w_rs2];
  always_ff @(posedge clk or posedge rst)
    if (rst)
      r_rf <= '{default: '0};
    else if (RegWriteW && RDW != '0)
      r_rf[RDW] <= ResultW;
  assign StallD = ValidD & ValidE & (ResultSrcE == 2'b01) & (RD_E != '0) &
                  ((w_use1 & (w_rs1 == RD_E)) | (w_use2 & (w_rs2 == RD_E)));
  assign w_bubble = FlushE | StallD | ~ValidD;
  assign w_next = w_bubble ? '0 : {1'b1, w_rw, w_as, w_mw, w_br, w_jp, w_il, w_rs, w_ac,
                                   w_rd1, w_rd2, w_imm, PCD, PCPlus4D, w_rd, w_rs1, w_rs2};
  always_ff @(posedge clk or posedge rst)
    if (rst)
      r_e <= '0;
    else
      r_e <= w_next;
  assign {ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, IllegalE, ResultSrcE, ALUControlE,
          RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, RS1_E, RS2_E} = r_e;
endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p: directed and randomized checks of decode_stage_p against an instruction-level model.
module tb_decode_stage_p;
  typedef struct packed {
    logic v, rw, as, mw, br, jp, il;
    logic [1:0] rs;
    logic [2:0] ac;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0] rd, s1, s2;
  } e_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
  logic ValidD = 1'b0, RegWriteW = 1'b0, FlushE = 1'b0;
  logic [4:0] RDW = '0;
  logic StallD, ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, IllegalE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0] RD_E, RS1_E, RS2_E;
  int checks = 0, fails = 0;
  logic [31:0] pc = 32'h1000;
  e_t exp_e, dut_e;
  logic [31:0] m_rf [32];
  decode_stage_p dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE), .StallD(StallD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .IllegalE(IllegalE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RD_E(RD_E), .RS1_E(RS1_E), .RS2_E(RS2_E)
  );
  assign dut_e = {ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, IllegalE, ResultSrcE,
                  ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, RS1_E, RS2_E};
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [191:0] got, input logic [191:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask
  function automatic logic [31:0] rd_reg(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (RegWriteW && RDW == a) return ResultW;
    return m_rf[a];
  endfunction
  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction
  function automatic e_t model(input logic [31:0] ins);
    e_t e = '0;
    e.v = 1'b1;
    e.pc = PCD;
    e.pc4 = PCPlus4D;
    e.rd = ins[11:7];
    e.s1 = ins[19:15];
    e.s2 = ins[24:20];
    e.rd1 = rd_reg(e.s1);
    e.rd2 = rd_reg(e.s2);
    case (ins[6:0])
      7'h33: begin e.rw = 1; e.ac = alu_of(ins[14:12], ins[30]); end
      7'h13: begin e.rw = 1; e.as = 1; e.ac = alu_of(ins[14:12], 1'b0); e.imm = 32'($signed(ins[31:20])); end
      7'h03: begin e.rw = 1; e.as = 1; e.rs = 2'b01; e.imm = 32'($signed(ins[31:20])); end
      7'h23: begin e.mw = 1; e.as = 1; e.imm = 32'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin e.br = 1; e.ac = 3'b001; e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); end
      7'h6F: begin e.jp = 1; e.rw = 1; e.rs = 2'b10; e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
      default: e.il = 1;
    endcase
    return e;
  endfunction
  function automatic logic exp_stall();
    logic [6:0] op = InstrD[6:0];
    logic u1 = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
    logic u2 = op inside {7'h33, 7'h23, 7'h63};
    return ValidD && exp_e.v && exp_e.rs == 2'b01 && exp_e.rd != 5'd0 &&
           ((u1 && InstrD[19:15] == exp_e.rd) || (u2 && InstrD[24:20] == exp_e.rd));
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      exp_e <= '0;
      m_rf <= '{default: '0};
    end else begin
      exp_e <= (FlushE || exp_stall() || !ValidD) ? '0 : model(InstrD);
      if (RegWriteW && RDW != 5'd0) m_rf[RDW] <= ResultW;
    end
  always @(negedge clk) begin
    chk("e_stage", dut_e, exp_e);
    chk("stall", StallD, exp_stall());
  end
  task automatic set(input logic [31:0] ins, input logic v, input logic rw, input logic [4:0] rdw,
                     input logic [31:0] res, input logic fl);
    InstrD = ins; ValidD = v; RegWriteW = rw; RDW = rdw; ResultW = res; FlushE = fl;
    PCD = pc; PCPlus4D = pc + 32'd4; pc += 32'd4;
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  logic [6:0] ops [7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h7F};
  logic [31:0] ins;
  int k;
  initial begin
    repeat (2) tick();
    chk("reset_e", dut_e, 192'd0);
    chk("reset_stall", StallD, 1'b0);
    rst = 1'b0;
    set(32'd0, 0, 1, 5'd1, 32'd5, 0); tick();
    set(32'd0, 0, 1, 5'd2, 32'd7, 0); tick();
    set(32'h002081B3, 1, 0, 5'd0, 32'd0, 0); tick();
    chk("r_rd1", RD1_E, 32'd5);
    chk("r_rd2", RD2_E, 32'd7);
    chk("r_alu", ALUControlE, 3'b000);
    chk("r_regwrite", RegWriteE, 1'b1);
    chk("r_rd", RD_E, 5'd3);
    set(32'h002081B3, 1, 1, 5'd1, 32'hAA, 0); tick();
    chk("bypass_rd1", RD1_E, 32'hAA);
    set(32'h000001B3, 1, 1, 5'd0, 32'h55, 0); tick();
    chk("x0_rd1", RD1_E, 32'd0);
    set(32'h0000A283, 1, 0, 5'd0, 32'd0, 0); tick();
    set(32'h00228333, 1, 0, 5'd0, 32'd0, 0);
    #1 chk("lu_stall", StallD, 1'b1);
    tick();
    chk("lu_bubble", ValidE, 1'b0);
    #1 chk("lu_release", StallD, 1'b0);
    tick();
    chk("lu_issue_v", ValidE, 1'b1);
    chk("lu_issue_rd", RD_E, 5'd6);
    set(32'h0000A283, 1, 0, 5'd0, 32'd0, 0); tick();
    set(32'hFE028CE3, 1, 0, 5'd0, 32'd0, 1);
    #1 chk("flush_stall", StallD, 1'b1);
    tick();
    chk("flush_e", dut_e, 192'd0);
    set(32'hFE000CE3, 1, 0, 5'd0, 32'd0, 0); tick();
    chk("beq_imm", Imm_Ext_E, 32'hFFFFFFF8);
    chk("beq_br", BranchE, 1'b1);
    chk("beq_alu", ALUControlE, 3'b001);
    set(32'h001000EF, 1, 0, 5'd0, 32'd0, 0); tick();
    chk("jal_imm", Imm_Ext_E, 32'h800);
    chk("jal_jump", JumpE, 1'b1);
    set(32'h0000007F, 1, 0, 5'd0, 32'd0, 0); tick();
    chk("ill_flag", IllegalE, 1'b1);
    chk("ill_ctrl", {RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, ResultSrcE, ALUControlE}, 10'd0);
    set(32'h002081B3, 1, 0, 5'd0, 32'd0, 0);
    rst = 1'b1;
    #1 chk("rst_async_e", dut_e, 192'd0);
    chk("rst_stall", StallD, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_first_v", ValidE, 1'b1);
    chk("rst_rd1", RD1_E, 32'd0);
    chk("rst_rd2", RD2_E, 32'd0);
    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 6);
      ins = $urandom;
      ins[6:0] = (k == 6) ? 7'($urandom) : ops[k];
      ins[11:7] = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      set(ins, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
          $urandom, $urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/decode_stage_p.md
DECODE_STAGE_P -- requirements
Module: decode_stage_p

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (≥32).
REQ-002 SHALL have parameter REG_AW, default 5, register index width; NREGS = 2^REG_AW.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have inputs InstrD (32), PCD (XLEN), PCPlus4D (XLEN) and ValidD (1, instruction present in D).
REQ-006 SHALL have writeback inputs RegWriteW (1), RDW (REG_AW) and ResultW (XLEN).
REQ-007 SHALL have input FlushE (1), which kills the instruction entering E.
REQ-008 SHALL have output StallD (1), combinational load-use hazard; upstream holds F/D while high.
REQ-009 SHALL have registered outputs ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, IllegalE (1 each), ResultSrcE (2), ALUControlE (3), RD1_E/RD2_E/Imm_Ext_E/PCE/PCPlus4E (XLEN), RD_E/RS1_E/RS2_E (REG_AW).

Function
REQ-010 SHALL implement NREGS×XLEN register file; reads of x0 return 0; writes to x0 ignored.
REQ-011 SHALL write ResultW to RDW at rising clk when RegWriteW=1.
REQ-012 SHALL bypass: read of RDW≠0 while RegWriteW=1 returns ResultW in the same cycle.
REQ-013 SHALL decode opcode: 0110011 R (RegWrite, ALUSrc=0); 0010011 I-ALU (RegWrite, ALUSrc); 0000011 load (RegWrite, ALUSrc, ResultSrc=01, add); 0100011 store (MemWrite, ALUSrc, add); 1100011 branch (Branch, sub); 1101111 jal (Jump, RegWrite, ResultSrc=10).
REQ-014 SHALL set all controls 0 and IllegalE=1 for any other opcode with ValidD=1.
REQ-015 SHALL map ALUControl for R/I-ALU by funct3: 000 add (sub when R and funct7[5]=1), 010 slt=101, 110 or=011, 111 and=010, others add=000; sub=001.
REQ-016 SHALL sign-extend imm to XLEN: I [31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; J {[31],[19:12],[20],[30:21],0}; R → 0.
REQ-017 SHALL treat rs1 as used by R, I-ALU, load, store and branch, and rs2 as used by R, store and branch.
REQ-018 SHALL assert StallD when ValidD & ValidE & ResultSrcE=01 & RD_E≠0 & (RD_E matches a used rs).
REQ-019 SHALL, each rising clk, select the E register next value by priority: FlushE → bubble; StallD → bubble; ValidD=0 → bubble; else load decoded fields.
REQ-020 SHALL have a bubble clear every registered output to 0.
REQ-021 SHALL have a latency of exactly one cycle from D inputs to E outputs.
REQ-022 SHALL, on a stalled cycle, leave the register file write unaffected; REQ-012 applies, so a replayed read sees writeback data.

Reset
REQ-023 SHALL, while rst=1, asynchronously force all E outputs and all register-file entries to 0.
REQ-024 SHALL hold StallD=0 during reset, as ValidE=0.
REQ-025 SHALL have the first clk after rst deasserts load E normally.
REQ-026 SHALL discard an instruction in flight at mid-operation reset.

Verification
REQ-027 SHALL cover R-type: x1=5, x2=7 written; InstrD=add x3,x1,x2 (0x002081B3) → next cycle RD1_E=5, RD2_E=7, ALUControlE=000, RegWriteE=1, RD_E=3.
REQ-028 SHALL cover bypass: RegWriteW=1, RDW=1, ResultW=0xAA while decoding rs1=x1 → RD1_E=0xAA same edge; RDW=0 write → x0 still reads 0.
REQ-029 SHALL cover load-use: lw x5,0(x1) in E, then add x6,x5,x2 in D → StallD=1, next ValidE=0; following cycle add issues with StallD=0.
REQ-030 SHALL cover flush priority: FlushE=1 with StallD=1 and valid branch in D → all E outputs 0.
REQ-031 SHALL cover immediates: beq offset −8 → Imm_Ext_E=0xFFFFFFF8, BranchE=1, ALUControlE=001; jal +2048 → Imm_Ext_E=0x800, JumpE=1.
REQ-032 SHALL cover illegal opcode and reset: opcode 1111111 → IllegalE=1, other controls 0; rst pulse mid-stream → outputs 0 immediately, registers read 0.
